adc_frame_reader: RTL and testbench

- Downstream consumer of the single-channel ADC capture stage.
- Once a capture completes, it drains that stage's sample FIFO and emits one framed byte stream on a valid/ready byte interface for the host link (UART/MCU bridge).
- After the last byte of a frame is accepted, it pulses the capture stage's restart input to re-arm acquisition.
- One instance per channel.

---
 rtl/adc_frame_reader.sv | 146 ++++++++++++++
 tb/tb_adc_frame_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_reader.sv
// Drains the ADC capture FIFO into a framed valid/ready byte stream and re-arms capture.
// Optional trailing checksum byte: define ADC_FRAME_CHECKSUM_EN.
module adc_frame_reader #(
   parameter int unsigned FRAME_LEN  = 4096,
   parameter logic [7:0]  CHANNEL_ID = 8'h00
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        ADC_end,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_q,
   output logic        fifo_rdreq,
   output logic        ADC_bg,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        underrun,
   output logic [15:0] frame_cnt
);

   localparam logic [15:0] LEN16    = 16'(FRAME_LEN);
   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, HDR0, HDR1, HID, LENH, LENL, FETCH, WAIT, SEND, DONE
`ifdef ADC_FRAME_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t      state, state_nxt;
   logic        adc_end_d;
   logic        start;
   logic        pad;
   logic [15:0] sample_cnt;
   logic [7:0]  sample_q;
   logic        underrun_q;
   logic [15:0] frame_cnt_q;
`ifdef ADC_FRAME_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   assign start = ADC_end && !adc_end_d && (state == IDLE);
   // Once underrun is flagged the FIFO is no longer touched for the rest of the frame.
   assign pad   = fifo_empty || underrun_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start)    state_nxt = HDR0;
         HDR0:  if (tx_ready) state_nxt = HDR1;
         HDR1:  if (tx_ready) state_nxt = HID;
         HID:   if (tx_ready) state_nxt = LENH;
         LENH:  if (tx_ready) state_nxt = LENL;
         LENL:  if (tx_ready) state_nxt = FETCH;
         FETCH: state_nxt = pad ? SEND : WAIT;
         WAIT:  state_nxt = SEND;
         SEND: begin
            if (tx_ready) begin
               if (sample_cnt == LAST_IDX)
`ifdef ADC_FRAME_CHECKSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = DONE;
`endif
               else
                  state_nxt = FETCH;
            end
         end
`ifdef ADC_FRAME_CHECKSUM_EN
         CSUM:  if (tx_ready) state_nxt = DONE;
`endif
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_valid   = 1'b0;
      tx_data    = '0;
      fifo_rdreq = 1'b0;
      ADC_bg     = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE:  busy = 1'b0;
         HDR0:  begin tx_valid = 1'b1; tx_data = 8'hA5;        end
         HDR1:  begin tx_valid = 1'b1; tx_data = 8'h5A;        end
         HID:   begin tx_valid = 1'b1; tx_data = CHANNEL_ID;   end
         LENH:  begin tx_valid = 1'b1; tx_data = LEN16[15:8];  end
         LENL:  begin tx_valid = 1'b1; tx_data = LEN16[7:0];   end
         FETCH: fifo_rdreq = !pad;
         SEND:  begin tx_valid = 1'b1; tx_data = sample_q;     end
`ifdef ADC_FRAME_CHECKSUM_EN
         CSUM:  begin tx_valid = 1'b1; tx_data = csum_q;       end
`endif
         DONE:  begin ADC_bg = 1'b1; busy = 1'b0;              end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         adc_end_d   <= 1'b0;
         sample_cnt  <= '0;
         sample_q    <= '0;
         underrun_q  <= 1'b0;
         frame_cnt_q <= '0;
`ifdef ADC_FRAME_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         adc_end_d <= ADC_end;
         if (start) begin
            sample_cnt <= '0;
            underrun_q <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
            csum_q     <= '0;
`endif
         end
         if (state == FETCH && pad) begin
            underrun_q <= 1'b1;
            sample_q   <= '0;
         end
         if (state == WAIT)
            sample_q <= fifo_q;
         if (state == SEND && tx_ready) begin
            sample_cnt <= sample_cnt + 16'd1;
`ifdef ADC_FRAME_CHECKSUM_EN
            csum_q     <= csum_q + sample_q;
`endif
         end
         if (state == DONE)
            frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign underrun  = underrun_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: FIFO model, byte monitor and frame-level reference model.
module tb_adc_frame_reader;

   localparam int unsigned FRAME_LEN  = 4;
   localparam logic [7:0]  CHANNEL_ID = 8'h03;
`ifdef ADC_FRAME_CHECKSUM_EN
   localparam bit HAS_CSUM = 1'b1;
`else
   localparam bit HAS_CSUM = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset_n, ADC_end, fifo_empty, tx_ready;
   logic [7:0]  fifo_q = '0;
   logic        fifo_rdreq, ADC_bg, tx_valid, busy, underrun;
   logic [7:0]  tx_data;
   logic [15:0] frame_cnt;

   adc_frame_reader #(.FRAME_LEN(FRAME_LEN), .CHANNEL_ID(CHANNEL_ID)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .ADC_end(ADC_end), .fifo_empty(fifo_empty),
      .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .ADC_bg(ADC_bg), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .underrun(underrun),
      .frame_cnt(frame_cnt)
   );

   always #5 Clk = ~Clk;

   logic [7:0] mem[$], stim[$], rx[$], exp_b[$];
   int checks = 0, failures = 0;
   int rd_cnt, rd_empty_err, bg_cnt, stall_err, cyc = 0, last_xfer_cyc, bg_cyc;
   int rdy_mode = 0, exp_frames = 0;
   logic stall_prev = 1'b0;
   logic [7:0] prev_data = '0;

   // Normal (non-show-ahead) FIFO: data appears the cycle after the read strobe.
   always @(posedge Clk) begin
      logic [7:0] b;
      if (fifo_rdreq && mem.size() > 0) begin
         b = mem.pop_front();
         fifo_q     <= b;
         fifo_empty <= (mem.size() == 0);
      end
   end

   always @(negedge Clk) begin
      cyc++;
      if (fifo_rdreq) rd_cnt++;
      if (fifo_rdreq && fifo_empty) rd_empty_err++;
      if (ADC_bg) begin bg_cnt++; bg_cyc = cyc; end
      if (!Reset_n) stall_prev = 1'b0;
      else begin
         if (stall_prev && (!tx_valid || tx_data !== prev_data)) stall_err++;
         if (tx_valid && tx_ready) begin rx.push_back(tx_data); last_xfer_cyc = cyc; end
         stall_prev = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge Clk); #1;
         case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Reference frame: header, FRAME_LEN samples (zero-padded past FIFO contents), optional sum.
   task automatic build_exp();
      int unsigned sum = 0;
      logic [7:0] b;
      logic [15:0] len = 16'(FRAME_LEN);
      exp_b.delete();
      exp_b.push_back(8'hA5); exp_b.push_back(8'h5A); exp_b.push_back(CHANNEL_ID);
      exp_b.push_back(len[15:8]); exp_b.push_back(len[7:0]);
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
         b = (i < stim.size()) ? stim[i] : 8'h00;
         exp_b.push_back(b);
         sum += b;
      end
      if (HAS_CSUM) exp_b.push_back(8'(sum % 256));
   endtask

   function automatic int frame_diff();
      int n = 0;
      if (rx.size() != exp_b.size()) return 1000 + rx.size();
      foreach (rx[i]) if (rx[i] !== exp_b[i]) n++;
      return n;
   endfunction

   function automatic int exp_reads();
      return (stim.size() < FRAME_LEN) ? stim.size() : FRAME_LEN;
   endfunction

   task automatic clear_mon();
      rx.delete(); rd_cnt = 0; rd_empty_err = 0; bg_cnt = 0; stall_err = 0;
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge Clk);
         if (bg_cnt != 0) begin to = 1'b0; break; end
      end
      repeat (2) @(posedge Clk); #1;
      if (!to) exp_frames++;
      build_exp();
   endtask

   task automatic run_frame(input int mode, output bit to);
      mem = stim; fifo_empty = (mem.size() == 0); rdy_mode = mode;
      clear_mon();
      ADC_end = 1'b0;
      repeat (2) @(posedge Clk); #1;
      ADC_end = 1'b1;
      wait_done(to);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; ADC_end = 1'b0; fifo_empty = 1'b1;
      repeat (3) @(negedge Clk);
      checks++;
      if ({tx_valid, tx_data, fifo_rdreq, ADC_bg, busy, underrun, frame_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b d=%h rd=%b bg=%b busy=%b ur=%b fc=%0d want all 0",
                  tx_valid, tx_data, fifo_rdreq, ADC_bg, busy, underrun, frame_cnt);
      end
      @(posedge Clk); #1 Reset_n = 1'b1;
      repeat (2) @(posedge Clk); #1;
   endtask

   task automatic test_basic();
      bit to;
      int d;
      stim = '{8'd10, 8'd20, 8'd30, 8'd40};
      run_frame(0, to);
      d = frame_diff();
      checks++; if (to) begin failures++; $display("FAIL basic_timeout got no ADC_bg want 1"); end
      checks++; if (d != 0) begin failures++; $display("FAIL basic_frame got %0d bytes, %0d diffs want %0d bytes, 0 diffs", rx.size(), d, exp_b.size()); end
      checks++; if (rd_cnt != exp_reads()) begin failures++; $display("FAIL basic_rdreq got %0d want %0d", rd_cnt, exp_reads()); end
      checks++; if (bg_cnt != 1) begin failures++; $display("FAIL basic_adc_bg got %0d want 1", bg_cnt); end
      checks++; if (bg_cyc != last_xfer_cyc + 1) begin failures++; $display("FAIL basic_bg_timing got cycle %0d want %0d", bg_cyc, last_xfer_cyc + 1); end
      checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL basic_underrun got %b want 0", underrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got %b want 0", busy); end
   endtask

   task automatic test_retrigger();
      bit to;
      clear_mon();
      repeat (30) @(posedge Clk); #1;
      checks++; if (bg_cnt != 0 || rx.size() != 0) begin failures++; $display("FAIL hold_no_retrigger got bg=%0d bytes=%0d want 0 0", bg_cnt, rx.size()); end
      stim = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(0, to);
      checks++; if (to || frame_diff() != 0) begin failures++; $display("FAIL retrigger_frame got to=%b diffs=%0d want 0 0", to, frame_diff()); end
      checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL retrigger_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_stall();
      bit to;
      stim = '{8'd10, 8'd20, 8'd30, 8'd40};
      run_frame(1, to);
      checks++; if (to || frame_diff() != 0) begin failures++; $display("FAIL stall_frame got to=%b bytes=%0d diffs=%0d want 0 %0d 0", to, rx.size(), frame_diff(), exp_b.size()); end
      checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_stable got %0d violations want 0", stall_err); end
      checks++; if (rd_cnt != exp_reads()) begin failures++; $display("FAIL stall_rdreq got %0d want %0d", rd_cnt, exp_reads()); end
   endtask

   task automatic test_underrun();
      bit to;
      stim = '{8'd10, 8'd20};
      run_frame(0, to);
      checks++; if (to || frame_diff() != 0) begin failures++; $display("FAIL underrun_frame got to=%b bytes=%0d diffs=%0d want 0 %0d 0", to, rx.size(), frame_diff(), exp_b.size()); end
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_flag got %b want 1", underrun); end
      checks++; if (rd_cnt != 2) begin failures++; $display("FAIL underrun_rdreq got %0d want 2", rd_cnt); end
      checks++; if (rd_empty_err != 0) begin failures++; $display("FAIL underrun_rd_empty got %0d want 0", rd_empty_err); end
      repeat (5) @(posedge Clk); #1;
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_hold got %b want 1", underrun); end
   endtask

   task automatic test_random();
      bit to;
      int n;
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(0, 6);
         stim.delete();
         for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
         run_frame(2, to);
         checks++;
         if (to || frame_diff() != 0 || rd_cnt != exp_reads() || rd_empty_err != 0 || stall_err != 0) begin
            failures++;
            $display("FAIL random_frame[%0d] got to=%b diffs=%0d rd=%0d rd_empty=%0d stall=%0d want 0 0 %0d 0 0",
                     k, to, frame_diff(), rd_cnt, rd_empty_err, stall_err, exp_reads());
         end
         checks++;
         if (underrun !== (n < FRAME_LEN) || frame_cnt !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL random_status[%0d] got ur=%b fc=%0d want %b %0d", k, underrun, frame_cnt, n < FRAME_LEN, exp_frames);
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit to;
      int i;
      stim = '{8'h01, 8'h02, 8'h03, 8'h04};
      mem = stim; fifo_empty = 1'b0; rdy_mode = 0;
      clear_mon();
      ADC_end = 1'b0;
      repeat (2) @(posedge Clk); #1;
      ADC_end = 1'b1;
      for (i = 0; i < 200 && rx.size() < 6; i++) @(posedge Clk);
      checks++; if (rx.size() < 6) begin failures++; $display("FAIL midreset_reach got %0d bytes want 6", rx.size()); end
      #1 Reset_n = 1'b0;
      @(negedge Clk);
      exp_frames = 0;
      checks++;
      if ({tx_valid, tx_data, fifo_rdreq, ADC_bg, busy, underrun, frame_cnt} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got v=%b d=%h rd=%b bg=%b busy=%b ur=%b fc=%0d want all 0",
                  tx_valid, tx_data, fifo_rdreq, ADC_bg, busy, underrun, frame_cnt);
      end
      repeat (3) @(posedge Clk); #1;
      checks++; if (bg_cnt != 0) begin failures++; $display("FAIL midreset_no_bg got %0d want 0", bg_cnt); end
      stim = '{8'hF0, 8'h0F, 8'h80, 8'h7F};
      mem = stim; fifo_empty = 1'b0;
      clear_mon();
      Reset_n = 1'b1;
      wait_done(to);
      checks++; if (to || frame_diff() != 0) begin failures++; $display("FAIL midreset_newframe got to=%b bytes=%0d diffs=%0d want 0 %0d 0", to, rx.size(), frame_diff(), exp_b.size()); end
      checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL midreset_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retrigger();
      test_stall();
      test_underrun();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
